cordic_sincos_core: RTL

- Iterative rotation-mode CORDIC engine for the baby_cordic peripheral.
- Accepts an angle in Q3.16 radians and produces cosine and sine in Q3.16 (19-bit signed, 3 integer bits incl. sign, 16 fraction bits).
- Results feed directly into the fixed-to-IEEE-float conversion stage.
- Processes one micro-rotation per clock and carries a start/busy/done handshake toward the peripheral register interface.

---
 rtl/cordic_sincos_core.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cordic_sincos_core.sv
// Iterative rotation-mode CORDIC: Q3.16 angle in, Q3.16 cos/sin out.
// Optional CORDIC_QUADRANT_FOLD_EN extends the input range to +/-pi.
module cordic_sincos_core #(
  parameter int ITERS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [18:0] angle_in,
  output logic               busy,
  output logic               done,
  output logic signed [18:0] cos_out,
  output logic signed [18:0] sin_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic signed [18:0] K = 19'sd39797;
  localparam logic [3:0] LAST = 4'(ITERS - 1);

  state_t state, state_nx;
  logic signed [18:0] x, y, z;
  logic [3:0] it;
  logic load, step, fin;
  logic dir;
  logic signed [18:0] x_sh, y_sh, atan_i;
  logic signed [18:0] x_nx, y_nx, z_nx;
  logic signed [18:0] z0, cos_res, sin_res;

  function automatic logic signed [18:0] atan_lut(input logic [3:0] k);
    logic signed [18:0] v;
    unique case (k)
      4'd0:  v = 19'sd51472;
      4'd1:  v = 19'sd30386;
      4'd2:  v = 19'sd16055;
      4'd3:  v = 19'sd8150;
      4'd4:  v = 19'sd4091;
      4'd5:  v = 19'sd2047;
      4'd6:  v = 19'sd1024;
      4'd7:  v = 19'sd512;
      4'd8:  v = 19'sd256;
      4'd9:  v = 19'sd128;
      4'd10: v = 19'sd64;
      4'd11: v = 19'sd32;
      4'd12: v = 19'sd16;
      4'd13: v = 19'sd8;
      4'd14: v = 19'sd4;
      4'd15: v = 19'sd2;
      default: v = 19'sd0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (it == LAST) state_nx = DONE;
      end
      DONE: begin
        fin = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Direction follows the sign of the residual angle.
  always_comb begin
    dir    = ~z[18];
    x_sh   = x >>> it;
    y_sh   = y >>> it;
    atan_i = atan_lut(it);
    x_nx   = dir ? x - y_sh : x + y_sh;
    y_nx   = dir ? y + x_sh : y - x_sh;
    z_nx   = dir ? z - atan_i : z + atan_i;
  end

`ifdef CORDIC_QUADRANT_FOLD_EN
  localparam logic signed [18:0] HALF_PI = 19'sd102944;
  localparam logic signed [18:0] NHALF_PI = -19'sd102944;
  localparam logic signed [18:0] PI = 19'sd205887;

  logic neg, neg0;

  // Fold outer quadrants by pi; the result is negated on the way out.
  always_comb begin
    z0   = angle_in;
    neg0 = 1'b0;
    if (angle_in > HALF_PI) begin
      z0   = angle_in - PI;
      neg0 = 1'b1;
    end else if (angle_in < NHALF_PI) begin
      z0   = angle_in + PI;
      neg0 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) neg <= 1'b0;
    else if (load) neg <= neg0;
  end

  assign cos_res = neg ? -x : x;
  assign sin_res = neg ? -y : y;
`else
  assign z0      = angle_in;
  assign cos_res = x;
  assign sin_res = y;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      it      <= '0;
      done    <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      state <= state_nx;
      done  <= fin;
      if (fin) begin
        cos_out <= cos_res;
        sin_out <= sin_res;
      end
      if (load) begin
        x  <= K;
        y  <= '0;
        z  <= z0;
        it <= '0;
      end else if (step) begin
        x  <= x_nx;
        y  <= y_nx;
        z  <= z_nx;
        it <= it + 4'd1;
      end
    end
  end

  assign busy = (state == RUN);

endmodule
